// File: rtl/rv_fifo_pkg.sv
// Purpose : shared sizing helpers for the rv_fifo block.
// Contents: ptr_width(depth)   - read/write pointer width (index bits + wrap bit)
//           level_width(depth) - width of the occupancy count 0..depth
package rv_pkg;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rv_fifo_if.sv
// Purpose : ready/valid handshake bundle for rv_fifo (producer side + consumer side).
// Signals : in_data/in_valid/in_ready   - producer -> FIFO, push = in_valid & in_ready
//           out_data/out_valid/out_ready - FIFO -> consumer, pop = out_valid & out_ready
// Modports: slave  - the FIFO itself
//           master - the environment driving producer data and consumer ready
interface rv_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/rv_fifo_mem.sv
// Purpose : DEPTH x DATA_WIDTH register array, one synchronous write port,
//           one asynchronous read port, no reset.
// Ports   : clk      - write clock
//           i_we     - write enable
//           i_waddr  - write index
//           i_wdata  - write data
//           i_raddr  - read index
//           o_rdata  - read data (combinational from i_raddr)
module rv_fifo_mem #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rv_fifo.sv
// Purpose : parametrised ready/valid FIFO with registered backpressure,
//           occupancy output and synchronous flush.
// Ports   : clk    - clock, rising edge
//           rst_n  - asynchronous active-low reset
//           bus    - rv_fifo_if.slave handshake bundle (in_* producer, out_* consumer)
//           clear  - synchronous flush; drops any push offered in the same cycle
//           level  - number of stored entries, 0..DEPTH
//           full   - level == DEPTH
//           empty  - level == 0
module rv_fifo
  import rv_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4,
  localparam int LW         = level_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  rv_fifo_if.slave      bus,
  input  logic          clear,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_in_ready;

  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_wr_nxt;
  logic [PW-1:0] w_rd_nxt;
  logic [PW-1:0] w_lvl;
  logic [PW-1:0] w_lvl_nxt;

  assign w_lvl = r_wr_ptr - r_rd_ptr;
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                 (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign level = LW'(w_lvl);

  // clear wins over a concurrent push: the write is suppressed as well,
  // so storage is left untouched by the flush.
  assign w_push = bus.in_valid & r_in_ready & ~clear;
  assign w_pop  = ~empty & bus.out_ready;

  always_comb begin
    w_wr_nxt = r_wr_ptr;
    w_rd_nxt = r_rd_ptr;
    if (clear) begin
      w_wr_nxt = '0;
      w_rd_nxt = '0;
    end else begin
      if (w_push) w_wr_nxt = r_wr_ptr + PW'(1);
      if (w_pop)  w_rd_nxt = r_rd_ptr + PW'(1);
    end
  end

  assign w_lvl_nxt = w_wr_nxt - w_rd_nxt;

  // in_ready is computed from the next pointer pair, so it never depends
  // combinationally on out_ready; a pop from full re-opens it one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_nxt;
      r_rd_ptr   <= w_rd_nxt;
      r_in_ready <= (w_lvl_nxt != PW'(DEPTH));
    end
  end

  rv_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (bus.in_data),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (bus.out_data)
  );

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = ~empty;

endmodule

// File: tb/tb_rv_fifo.sv
module tb_rv_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] level;
  logic       full;
  logic       empty;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q [$];

  rv_fifo_if #(.DATA_WIDTH(8)) bus ();

  rv_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .clear (clear),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every pop seen on the consumer side is compared with the
  // oldest expected entry queued by the stimulus.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h expected no output", bus.out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          errors++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h", bus.out_data, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fill_vals [4];
    fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    #8;
    check("rst_in_ready",  32'(bus.in_ready),  0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_empty",     32'(empty),         1);
    check("rst_full",      32'(full),          0);
    check("rst_level",     32'(level),         0);
    #4 rst_n = 1'b1;
    tick();
    check("rel_in_ready", 32'(bus.in_ready), 1);

    // fill without popping
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = fill_vals[i];
      exp_q.push_back(fill_vals[i]);
      tick();
      check("fill_level", 32'(level), 32'(i + 1));
      check("fill_in_ready", 32'(bus.in_ready), (i == 3) ? 0 : 1);
    end
    check("fill_full", 32'(full), 1);
    bus.in_data = 8'h55;  // rejected: in_ready is low
    tick();
    check("full_reject_level", 32'(level), 4);
    bus.in_valid = 1'b0;

    // drain from full
    bus.out_ready = 1'b1;
    tick();
    check("drain_in_ready", 32'(bus.in_ready), 1);
    check("drain_level1",   32'(level),        3);
    tick(); tick(); tick();
    check("drain_empty",    32'(empty),        1);
    check("drain_q_empty",  32'(exp_q.size()), 0);

    // streaming through pointer wrap-around
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_data = 8'(i);
      exp_q.push_back(8'(i));
      tick();
      check("stream_level", 32'(level), 1);
    end
    bus.in_valid = 1'b0;
    tick();
    check("stream_empty", 32'(empty),        1);
    check("stream_q",     32'(exp_q.size()), 0);

    // clear colliding with a push
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 8'hC1 + 8'(i);
      tick();
    end
    check("clr_pre_level", 32'(level), 3);
    bus.in_data = 8'hAA;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_level",    32'(level),         0);
    check("clr_empty",    32'(empty),         1);
    check("clr_in_ready", 32'(bus.in_ready),  1);
    check("clr_valid",    32'(bus.out_valid), 0);
    bus.out_ready = 1'b1;  // any pop here would be flagged by the monitor
    tick(); tick();
    check("clr_stay_empty", 32'(empty), 1);

    // asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h61; tick();
    bus.in_data   = 8'h62; tick();
    bus.in_valid  = 1'b0;
    check("ar_pre_level", 32'(level), 2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(bus.out_valid), 0);
    check("ar_in_ready",  32'(bus.in_ready),  0);
    check("ar_level",     32'(level),         0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ar_rel_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    exp_q.push_back(8'h5A);
    tick();
    bus.in_valid = 1'b0;
    check("ar_push_level", 32'(level), 1);
    bus.out_ready = 1'b1;
    tick();
    check("ar_drained", 32'(empty), 1);
    tick();

    check("final_q_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
